// File: rtl/delay_line_pkg.sv
// Shared constants for the delay-line sensing chain (pulse generator, echo timer, host interface).
// Optional macro ECHO_TIMER_FILTER_EN turns on the echo qualification filter.
package delay_line_pkg;

    localparam int CTR_WIDTH_DEF    = 16;
    localparam int BLANK_CLKS_DEF   = 8;
    localparam int TIMEOUT_CLKS_DEF = 1000;
    localparam int SYNC_STAGES_DEF  = 2;
    localparam int FILTER_CLKS_DEF  = 3;

`ifdef ECHO_TIMER_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TX     = 3'd1,
        BLANK  = 3'd2,
        LISTEN = 3'd3,
        HOLD   = 3'd4
    } state_t;

    // Cycles between the echo edge and the cycle it is accepted; subtracted to recover the edge time.
    function automatic int filter_offset(input int filter_clks);
        return FILTER_EN ? filter_clks - 1 : 0;
    endfunction

endpackage

// File: rtl/echo_sync_det.sv
// Echo input synchroniser, rising-edge detector and, with ECHO_TIMER_FILTER_EN, a
// consecutive-high qualification filter that only runs while the timer is listening.
module echo_sync_det
    import delay_line_pkg::*;
#(
    parameter int CTR_WIDTH   = CTR_WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILTER_CLKS = FILTER_CLKS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 echo_in,
    input  logic                 listen,
    output logic                 echo_qual,
    output logic [CTR_WIDTH-1:0] qual_offset
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   echo_s;
    logic                   echo_prev_q;
    logic                   echo_edge;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= '0;
            echo_prev_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], echo_in};
            echo_prev_q <= echo_s;
        end
    end

    assign echo_s      = sync_q[SYNC_STAGES-1];
    assign echo_edge   = echo_s & ~echo_prev_q;
    assign qual_offset = CTR_WIDTH'(filter_offset(FILTER_CLKS));

`ifdef ECHO_TIMER_FILTER_EN
    if (FILTER_CLKS > 1) begin : g_filter
        localparam int RW = $clog2(FILTER_CLKS + 1);
        logic [RW-1:0] run_q;

        // run_q counts high samples since an edge seen inside LISTEN; 0 means not armed.
        always_ff @(posedge clk) begin
            if (reset || !listen) begin
                run_q <= '0;
            end else if (echo_edge) begin
                run_q <= RW'(1);
            end else if (!echo_s) begin
                run_q <= '0;
            end else if (run_q != '0 && run_q != RW'(FILTER_CLKS - 1)) begin
                run_q <= run_q + 1'b1;
            end
        end

        assign echo_qual = listen & echo_s & (run_q == RW'(FILTER_CLKS - 1));
    end else begin : g_single
        assign echo_qual = listen & echo_edge;
    end
`else
    assign echo_qual = listen & echo_edge;
`endif

endmodule

// File: rtl/echo_timer.sv
// Time-of-flight timer: starts on the transmit burst, blanks, then timestamps the first echo or times out.
// Build option: ECHO_TIMER_FILTER_EN adds multi-cycle echo qualification (see echo_sync_det).
//
// state  | meaning
// IDLE   | waiting for a transmit burst
// TX     | burst in progress, counter running
// BLANK  | post-burst ringing window, echoes ignored
// LISTEN | waiting for echo or timeout
// HOLD   | result presented until accepted
module echo_timer
    import delay_line_pkg::*;
#(
    parameter int CTR_WIDTH    = CTR_WIDTH_DEF,
    parameter int BLANK_CLKS   = BLANK_CLKS_DEF,
    parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF,
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int FILTER_CLKS  = FILTER_CLKS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_active,
    input  logic                 echo_in,
    output logic [CTR_WIDTH-1:0] result,
    output logic                 result_timeout,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 busy,
    output logic                 overrun
);

    localparam int BW = (BLANK_CLKS < 1) ? 1 : $clog2(BLANK_CLKS + 1);

    state_t               state_q, state_d;
    logic [CTR_WIDTH-1:0] counter_q, counter_d, counter_inc;
    logic [CTR_WIDTH-1:0] result_q, result_d, qual_offset;
    logic [BW-1:0]        blank_q, blank_d;
    logic                 result_timeout_q, result_timeout_d;
    logic                 overrun_q, overrun_d;
    logic                 tx_prev_q, tx_rise;
    logic                 listen, echo_qual;

    echo_sync_det #(
        .CTR_WIDTH  (CTR_WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_CLKS(FILTER_CLKS)
    ) u_sync_det (
        .clk        (clk),
        .reset      (reset),
        .echo_in    (echo_in),
        .listen     (listen),
        .echo_qual  (echo_qual),
        .qual_offset(qual_offset)
    );

    assign tx_rise = tx_active & ~tx_prev_q;
    // Counter value as of the current edge, so a result equals the edge index it was captured on.
    assign counter_inc = (counter_q == '1) ? counter_q : counter_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            counter_q        <= '0;
            blank_q          <= '0;
            result_q         <= '0;
            result_timeout_q <= 1'b0;
            overrun_q        <= 1'b0;
            tx_prev_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            counter_q        <= counter_d;
            blank_q          <= blank_d;
            result_q         <= result_d;
            result_timeout_q <= result_timeout_d;
            overrun_q        <= overrun_d;
            tx_prev_q        <= tx_active;
        end
    end

    always_comb begin
        state_d          = state_q;
        counter_d        = counter_q;
        blank_d          = blank_q;
        result_d         = result_q;
        result_timeout_d = result_timeout_q;
        overrun_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_rise) begin
                    state_d   = TX;
                    counter_d = '0;
                end
            end
            TX: begin
                counter_d = counter_inc;
                if (!tx_active) begin
                    state_d = (BLANK_CLKS == 0) ? LISTEN : BLANK;
                    blank_d = BW'(BLANK_CLKS - 1);
                end
            end
            BLANK: begin
                counter_d = counter_inc;
                if (blank_q == '0) state_d = LISTEN;
                else               blank_d = blank_q - 1'b1;
            end
            LISTEN: begin
                counter_d = counter_inc;
                if (tx_rise) begin
                    state_d   = TX;
                    counter_d = '0;
                end else if (echo_qual) begin
                    state_d          = HOLD;
                    result_d         = counter_inc - qual_offset;
                    result_timeout_d = 1'b0;
                end else if (counter_inc >= CTR_WIDTH'(TIMEOUT_CLKS)) begin
                    state_d          = HOLD;
                    result_d         = CTR_WIDTH'(TIMEOUT_CLKS);
                    result_timeout_d = 1'b1;
                end
            end
            HOLD: begin
                if (result_ready) begin
                    state_d = tx_rise ? TX : IDLE;
                    if (tx_rise) counter_d = '0;
                end else if (tx_rise) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        listen         = (state_q == LISTEN);
        busy           = (state_q == TX) || (state_q == BLANK) || (state_q == LISTEN);
        result_valid   = (state_q == HOLD);
        result         = result_q;
        result_timeout = result_timeout_q;
        overrun        = overrun_q;
    end

endmodule

// File: tb/tb_echo_timer.sv
// Self-checking bench for echo_timer: directed scenarios plus randomized echo patterns
// checked against an edge-index model of the timing rules.
module tb_echo_timer;

    localparam int CW  = 16;
    localparam int BLK = 8;
    localparam int TMO = 1000;
    localparam int SYN = 2;
    localparam int FCP = 3;
`ifdef ECHO_TIMER_FILTER_EN
    localparam int FILT = FCP;
`else
    localparam int FILT = 1;
`endif

    logic          clk, reset, tx_active, echo_in, result_ready;
    logic [CW-1:0] result;
    logic          result_timeout, result_valid, busy, overrun;

    logic s [0:1023];
    int tests_run    = 0;
    int tests_failed = 0;

    echo_timer #(
        .CTR_WIDTH(CW), .BLANK_CLKS(BLK), .TIMEOUT_CLKS(TMO),
        .SYNC_STAGES(SYN), .FILTER_CLKS(FCP)
    ) dut (
        .clk(clk), .reset(reset), .tx_active(tx_active), .echo_in(echo_in),
        .result(result), .result_timeout(result_timeout), .result_valid(result_valid),
        .result_ready(result_ready), .busy(busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_pattern();
        for (int i = 0; i < 1024; i++) s[i] = 1'b0;
    endtask

    task automatic set_high(input int a, input int b);
        for (int i = a; i <= b; i++) s[i] = 1'b1;
    endtask

    // Expected outcome: burst high for sample edges 0..L-1; echo sample s[e] is seen as
    // echo_s at edge e+SYN; listening covers edges after L+BLK up to the timeout edge.
    function automatic void model(input int L, output int exp_k, output int exp_res, output bit exp_to);
        int q;
        bit ok;
        exp_k = TMO; exp_res = TMO; exp_to = 1'b1;
        for (int k = L + BLK + 1; k <= TMO; k++) begin
            if (s[k-SYN] && !s[k-SYN-1]) begin
                q  = k + FILT - 1;
                ok = (q <= TMO);
                for (int j = k - SYN; j <= q - SYN; j++) if (!s[j]) ok = 1'b0;
                if (ok) begin
                    exp_k = q; exp_res = k; exp_to = 1'b0;
                    return;
                end
            end
        end
    endfunction

    task automatic run_meas(input int L, input bit hs, output int obs_k);
        obs_k = -1;
        for (int k = 0; k <= TMO + 20; k++) begin
            @(negedge clk);
            tx_active    = (k < L);
            echo_in      = s[k];
            result_ready = hs && (k == 0);
            @(posedge clk); #1;
            if (hs && k == 0) begin
                tests_run++;
                if (result_valid !== 1'b0 || busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL handshake_restart: valid=%0b busy=%0b want valid=0 busy=1", result_valid, busy);
                end
            end
            if (result_valid === 1'b1) begin
                obs_k = k;
                break;
            end
        end
        @(negedge clk);
        tx_active = 1'b0; echo_in = 1'b0; result_ready = 1'b0;
    endtask

    task automatic check_meas(input string name, input int L, input bit hs);
        int ek, er, ok_k;
        bit et;
        model(L, ek, er, et);
        run_meas(L, hs, ok_k);
        tests_run++;
        if (ok_k < 0) begin
            tests_failed++;
            $display("FAIL %s no_result: result_valid never rose, want result %0d", name, er);
        end else begin
            if (int'(result) !== er) begin
                tests_failed++;
                $display("FAIL %s result: got %0d want %0d", name, result, er);
            end
            tests_run++;
            if (result_timeout !== et) begin
                tests_failed++;
                $display("FAIL %s timeout_flag: got %0b want %0b", name, result_timeout, et);
            end
            if (!et) begin
                tests_run++;
                if (ok_k !== ek) begin
                    tests_failed++;
                    $display("FAIL %s valid_edge: got %0d want %0d", name, ok_k, ek);
                end
            end
        end
    endtask

    task automatic accept(input int held);
        @(negedge clk); result_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || int'(result) !== held) begin
            tests_failed++;
            $display("FAIL accept: valid=%0b busy=%0b result=%0d want 0 0 %0d", result_valid, busy, result, held);
        end
        @(negedge clk); result_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        tests_run++;
        if (result !== '0 || result_timeout !== 1'b0 || result_valid !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: result=%0d to=%0b valid=%0b ovr=%0b busy=%0b want all 0",
                     result, result_timeout, result_valid, overrun, busy);
        end
        @(negedge clk); reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        clear_pattern(); set_high(50, 1023);
        check_meas("basic", 6, 1'b0);
        tests_run++;
        if (result !== 16'd52) begin
            tests_failed++;
            $display("FAIL basic_value: got %0d want 52", result);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (result_valid !== 1'b1 || result !== 16'd52) begin
                tests_failed++;
                $display("FAIL basic_hold: valid=%0b result=%0d want 1 52", result_valid, result);
            end
        end
        accept(52);
    endtask

    task automatic test_blanking();
        clear_pattern(); s[3] = 1'b1; s[10] = 1'b1;
        check_meas("blanking", 6, 1'b0);
        tests_run++;
        if (result !== 16'd1000 || result_timeout !== 1'b1) begin
            tests_failed++;
            $display("FAIL blanking_timeout: result=%0d to=%0b want 1000 1", result, result_timeout);
        end
        accept(1000);
    endtask

    task automatic test_level();
        clear_pattern(); set_high(4, 200); set_high(300, 1023);
        check_meas("level", 6, 1'b0);
        tests_run++;
        if (result !== 16'd302) begin
            tests_failed++;
            $display("FAIL level_value: got %0d want 302", result);
        end
        accept(302);
    endtask

    task automatic test_filter();
        int want;
        want = (FILT > 1) ? 82 : 62;
        clear_pattern(); set_high(60, 61); set_high(80, 1023);
        check_meas("filter", 6, 1'b0);
        tests_run++;
        if (int'(result) !== want) begin
            tests_failed++;
            $display("FAIL filter_value: got %0d want %0d", result, want);
        end
        accept(want);
    endtask

    task automatic random_pattern();
        int np, st, w;
        clear_pattern();
        np = $urandom_range(0, 4);
        for (int p = 0; p < np; p++) begin
            st = $urandom_range(0, 1000);
            w  = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 60) : $urandom_range(1, 6);
            set_high(st, (st + w - 1 > 1023) ? 1023 : st + w - 1);
        end
    endtask

    task automatic test_random();
        int ek, er;
        bit et;
        for (int n = 0; n < 12; n++) begin
            int L;
            random_pattern();
            L = $urandom_range(1, 20);
            check_meas("random", L, 1'b0);
            model(L, ek, er, et);
            accept(er);
        end
    endtask

    task automatic test_back_to_back();
        int ek, er;
        bit et;
        clear_pattern(); set_high(120, 1023);
        check_meas("b2b_first", 4, 1'b0);
        @(negedge clk); tx_active = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (overrun !== 1'b1 || result !== 16'd122 || result_valid !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_pulse: ovr=%0b result=%0d valid=%0b busy=%0b want 1 122 1 0",
                     overrun, result, result_valid, busy);
        end
        @(posedge clk); #1;
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_width: got %0b want 0", overrun);
        end
        repeat (3) @(negedge clk);
        tx_active = 1'b0;
        repeat (30) @(negedge clk);
        tests_run++;
        if (result_valid !== 1'b1 || result !== 16'd122 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_hold: valid=%0b result=%0d busy=%0b want 1 122 0", result_valid, result, busy);
        end
        random_pattern();
        check_meas("b2b_second", 7, 1'b1);
        model(7, ek, er, et);
        accept(er);
    endtask

    task automatic test_abort();
        int ek, er;
        bit et;
        clear_pattern();
        @(negedge clk); tx_active = 1'b1;
        repeat (5) @(negedge clk);
        tx_active = 1'b0;
        repeat (30) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1 || result_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_listening: busy=%0b valid=%0b want 1 0", busy, result_valid);
        end
        set_high($urandom_range(20, 900), 1023);
        check_meas("abort", 3, 1'b0);
        model(3, ek, er, et);
        accept(er);
    endtask

    task automatic test_reset_mid_blank();
        @(negedge clk); tx_active = 1'b1;
        repeat (5) @(negedge clk);
        tx_active = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (result !== '0 || result_timeout !== 1'b0 || result_valid !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_blank: result=%0d to=%0b valid=%0b ovr=%0b busy=%0b want all 0",
                     result, result_timeout, result_valid, overrun, busy);
        end
        @(negedge clk); reset = 1'b0; echo_in = 1'b1;
        repeat (3) @(negedge clk);
        echo_in = 1'b0;
        repeat (40) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_stays_idle: busy=%0b valid=%0b want 0 0", busy, result_valid);
        end
    endtask

    initial begin
        reset = 1'b1; tx_active = 1'b0; echo_in = 1'b0; result_ready = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_basic();
        test_blanking();
        test_level();
        test_filter();
        test_random();
        test_back_to_back();
        test_abort();
        test_reset_mid_blank();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/echo_timer.md
Name: echo_timer

Overview:
- Time-of-flight measurement stage downstream of the burst pulse generator.
- Starts timing when the transmit burst begins, which it sees from the generator's active output. Ignores the receive comparator during the burst and for a blanking window after it.
- Timestamps the first echo rising edge after blanking, or reports a timeout. Presents the result on a valid/ready handshake to the host interface.

Parameters:
- CTR_WIDTH, 16, width of the time counter and result.
- BLANK_CLKS, 8, cycles after tx_active falls during which echoes are ignored (0 allowed).
- TIMEOUT_CLKS, 1000, counter value at which listening gives up. Must be < 2^CTR_WIDTH - 1.
- SYNC_STAGES, 2, flops in the echo_in synchroniser (>= 2).
- FILTER_CLKS, 3, consecutive high samples required to qualify an echo (only with ECHO_TIMER_FILTER_EN; >= 1).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high reset.
- tx_active, input, 1, burst-in-progress flag from the pulse generator (same clock domain).
- echo_in, input, 1, asynchronous comparator output from the receiver.
- result, output, CTR_WIDTH, measured time in clk cycles.
- result_timeout, output, 1, qualifies result: 1 means no echo was seen before timeout.
- result_valid, output, 1, result available.
- result_ready, input, 1, consumer accepts result.
- busy, output, 1, measurement in progress (any state except IDLE and HOLD).
- overrun, output, 1, one-cycle pulse when a burst starts while a result is still unread.

Behaviour:
- Reset: state IDLE, counter 0, result 0, result_timeout 0, result_valid 0, overrun 0, synchroniser flops 0. Reset in any state aborts immediately; no result is produced.
- echo_s is the last synchroniser stage. An echo edge means echo_s = 1 and the previous echo_s = 0.
- tx rise means tx_active = 1 and the registered previous tx_active = 0.
- Counter is 0 on the edge that first samples tx_active high, then increments once per edge. It saturates at all-ones and never wraps.
- Result rule: if tx rises at edge 0 and echo_in is first sampled high at edge E, then result = E + SYNC_STAGES. Synchroniser latency is included and not compensated.
- IDLE: on tx rise go to TX with counter 0.
- TX: counter runs. When tx_active is 0, go to BLANK with blank count 0. If BLANK_CLKS = 0, go directly to LISTEN.
- BLANK: counter runs; echo edges are ignored. After BLANK_CLKS cycles, go to LISTEN.
- LISTEN, evaluated in this priority order:
  - tx rise: abort, counter 0, go to TX; no result.
  - echo edge: result = counter, result_timeout = 0, result_valid = 1, go to HOLD.
  - counter == TIMEOUT_CLKS: result = TIMEOUT_CLKS, result_timeout = 1, result_valid = 1, go to HOLD.
- An echo_s already high on entry to LISTEN is not an edge; a fresh rising edge is required.
- HOLD: result, result_timeout and result_valid stay stable until result_valid & result_ready.
  - Handshake: result_valid drops next cycle and state goes to IDLE. If tx rises in the same cycle, go straight to TX with counter 0.
  - tx rise without a handshake: ignored, overrun pulses for 1 cycle, the held result is preserved, and that burst is not measured.
- The result register is written only on LISTEN exit. It holds its last value after the handshake.

Optional Feature:
- Macro: ECHO_TIMER_FILTER_EN.
- With the macro defined:
  - An echo qualifies only after echo_s has been high for FILTER_CLKS consecutive LISTEN cycles, starting from a rising edge inside LISTEN.
  - result = counter value at the qualifying cycle - (FILTER_CLKS - 1), i.e. the edge time.
  - A low sample restarts qualification. Timeout takes priority over a partially qualified echo.
- Without the macro: a single edge qualifies; the FILTER_CLKS parameter is ignored.

Decomposition:
- Package delay_line_pkg:
  - state encoding constants: IDLE, TX, BLANK, LISTEN, HOLD.
  - shared width/timing constants also used by the pulse generator and the host interface.
- Sub-module echo_sync_det: synchroniser chain, edge detector and optional filter. Outputs edge/qualified and filter-offset information to the echo_timer FSM.

Test Plan:
- Basic, SYNC_STAGES=2: tx_active high edges 0-5, echo_in rises before edge 50 -> result 52, result_timeout 0, result_valid held until result_ready.
- Blanking, BLANK_CLKS=8: echo pulses at edges 3 and 10 only -> no result. Counter reaches TIMEOUT_CLKS=1000 -> result 1000, result_timeout 1.
- Level at LISTEN entry: echo_in high from edge 4 to 200, then low, then rises at edge 300 -> result 302.
- Backpressure: result_ready low, second tx rise -> overrun 1-cycle pulse, result unchanged. Then result_ready with a simultaneous tx rise -> new measurement starts with counter 0.
- Abort and reset: tx rise during LISTEN -> restart with no result. Reset asserted mid-BLANK -> all outputs 0 next cycle, IDLE.
- With ECHO_TIMER_FILTER_EN, FILTER_CLKS=3:
  - 2-cycle glitch at edge 60 -> ignored.
  - Sustained echo sampled from edge 80 -> result 82.
